// File: rtl/decoder_arbiter_if.sv
// Request/grant bundle between four requesters and the decoder arbiter.
// master: requester side, slave: arbiter side.
interface decoder_arbiter_if;
  logic [3:0] req;
  logic [1:0] A;
  logic       E;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (output req, input A, E, gnt, busy, timeout);
  modport slave  (input req, output A, E, gnt, busy, timeout);
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder select/enable, with a hold
// limit and a forced one-cycle gap between consecutive grants.
module decoder_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic               clk,
  input logic               rst_n,
  decoder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] a_q, a_d;
  logic       e_q, e_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // Search last+1 .. last+4 (mod 4); the 2-bit add provides the wrap.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      a_q       <= '0;
      e_q       <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      e_q       <= e_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle, StRelease: begin
        if (found) begin
          state_d = StGrant;
          a_d     = win;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        cnt_d = (cnt_q == HoldLast) ? cnt_q : cnt_q + 8'd1;
        // last moves on entry to RELEASE so the next arbitration rotates past A.
        if (!bus.req[a_q]) begin
          state_d = StRelease;
          last_d  = a_q;
        end else if (cnt_q == HoldLast) begin
          state_d   = StRelease;
          last_d    = a_q;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are precomputed from the next state and registered alongside it.
  always_comb begin
    e_d    = (state_d == StGrant);
    busy_d = (state_d != StIdle);
    gnt_d  = e_d ? (4'b0001 << a_d) : 4'b0000;
  end

  assign bus.A       = a_q;
  assign bus.E       = e_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle sequences and a
// randomized run against a behavioural round-robin model.
module tb_decoder_arbiter;
  localparam int unsigned HoldMax = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_arbiter_if bus ();

  decoder_arbiter #(.HOLD_MAX(HoldMax)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 granting, 2 gap cycle.
  int   m_phase = 0;
  int   m_last  = 3;
  int   m_owner = 0;
  int   m_held  = 0;
  logic m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_phase = 0; m_last = 3; m_owner = 0; m_held = 0; m_to = 1'b0;
    end else if (m_phase == 1) begin
      m_held++;
      m_to = 1'b0;
      if (!bus.req[m_owner]) begin
        m_phase = 2; m_last = m_owner;
      end else if (m_held == HoldMax) begin
        m_phase = 2; m_last = m_owner; m_to = 1'b1;
      end
    end else begin
      m_to = 1'b0;
      w = pick(bus.req, m_last);
      if (w >= 0) begin
        m_phase = 1; m_owner = w; m_held = 0;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, "_A"}, 8'(bus.A), 8'(m_owner));
    check({tag, "_E"}, 8'(bus.E), 8'(m_phase == 1));
    check({tag, "_gnt"}, 8'(bus.gnt), 8'(eg));
    check({tag, "_busy"}, 8'(bus.busy), 8'(m_phase != 0));
    check({tag, "_timeout"}, 8'(bus.timeout), 8'(m_to));
  endtask

  // Advance one edge; outputs are settled when this returns.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] a;
    logic       e;
    logic [3:0] gnt;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int         owners[$];
    int         exp_order[5];
    int         run;
    int         tos;
    logic       prev_e;

    tbl[0]  = '{1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0011, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'b0011, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'b0001, 2'd1, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'b1001, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b1000, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'b1000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'b0101, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'b0100, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0101, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 4'b0101, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};

    rst_n   = 1'b0;
    bus.req = 4'b0000;

    for (int i = 0; i < 19; i++) begin
      rst_n   = tbl[i].rst_n;
      bus.req = tbl[i].req;
      tick();
      check($sformatf("vec%0d_A", i), 8'(bus.A), 8'(tbl[i].a));
      check($sformatf("vec%0d_E", i), 8'(bus.E), 8'(tbl[i].e));
      check($sformatf("vec%0d_gnt", i), 8'(bus.gnt), 8'(tbl[i].gnt));
      check($sformatf("vec%0d_busy", i), 8'(bus.busy), 8'(tbl[i].busy));
      check($sformatf("vec%0d_timeout", i), 8'(bus.timeout), 8'(tbl[i].to));
    end

    // All four requesting: rotation 0,1,2,3,0 with HOLD_MAX-long grants.
    rst_n = 1'b0; bus.req = 4'b0000;
    tick();
    rst_n = 1'b1; bus.req = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
    run = 0; tos = 0; prev_e = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      check_model("all");
      if (bus.E && !prev_e) owners.push_back(int'(bus.A));
      if (bus.E) run++;
      else if (prev_e) begin
        check("all_run_len", 8'(run), 8'(HoldMax));
        run = 0;
      end
      if (bus.timeout) tos++;
      prev_e = bus.E;
    end
    check("all_grant_count", 8'(owners.size()), 8'd5);
    check("all_timeouts", 8'(tos), 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < owners.size()) check($sformatf("all_order%0d", i), 8'(owners[i]), 8'(exp_order[i]));
    end

    // Lone requester 3: timeout every HOLD_MAX+1 cycles.
    rst_n = 1'b0; bus.req = 4'b0000;
    tick();
    rst_n = 1'b1; bus.req = 4'b1000;
    tos = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      check_model("lone");
      if (bus.E) check("lone_A", 8'(bus.A), 8'd3);
      if (bus.timeout) tos++;
    end
    check("lone_timeouts", 8'(tos), 8'd3);

    // Randomized run with sticky requests so long holds occur.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) bus.req = 4'($urandom);
      rst_n = ($urandom_range(63) != 0);
      tick();
      check_model("rand");
      check("rand_onehot", 8'($countones(bus.gnt) <= 1), 8'd1);
      check("rand_gnt_off", 8'(!bus.E && (bus.gnt != 4'b0000)), 8'd0);
      check("rand_to_e", 8'(bus.timeout && bus.E), 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
